// File: rtl/load_store_unit_if.sv
// load_store_unit_if: groups the MEM-stage request/response handshake and the
// word-addressed data-memory bus of the load/store unit.
//   req_*  : request from the MEM stage (valid/ready handshake)
//   resp_* : completion pulse with load data / misalignment flag
//   stall  : pipeline freeze, inverse of req_ready
//   mem_*  : word-indexed data memory (address, write data, strobes, read data)
// Modport slave is the load/store unit's view; master is the pipeline+memory view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_address, mem_write_data, mem_memwrite, mem_memread
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_address, mem_write_data, mem_memwrite, mem_memread
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word loads and stores on top of a word-only
// data memory. Sub-word stores are done as read-modify-write (RD then WR).
// Ports:
//   clk : single clock
//   rst : synchronous active-high reset
//   bus : load_store_unit_if.slave (request/response handshake + memory bus)
module load_store_unit (
  input logic            clk,
  input logic            rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        misaligned;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        lat_write;
  logic [31:0] lat_wdata;
  logic [31:0] old_word;
  logic [31:0] store_word;

  // Select the addressed lane of a word and sign/zero extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r = {word[31:8], data[7:0]};
          2'd1:    r = {word[31:16], data[7:0], word[7:0]};
          2'd2:    r = {word[31:24], data[7:0], word[15:0]};
          2'd3:    r = {data[7:0], word[23:0]};
          default: r = word;
        endcase
      end
      2'b01:   r = off[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  // Alignment check on the live request; size 11 behaves as a word.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      default: misaligned = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  assign accept     = (state == IDLE) && bus.req_valid;
  assign store_word = merge_lane(old_word, lat_wdata, lat_addr[1:0], lat_size);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs; strobes come only from the state register.
  always_comb begin
    state_next         = state;
    bus.req_ready      = 1'b0;
    bus.stall          = 1'b1;
    bus.resp_valid     = 1'b0;
    bus.mem_memread    = 1'b0;
    bus.mem_memwrite   = 1'b0;
    bus.mem_address    = 32'h0000_0000;
    bus.mem_write_data = 32'h0000_0000;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = 1'b0;
        if (bus.req_valid) begin
          if (misaligned) begin
            state_next = RESP;
          end else if (bus.req_write && bus.req_size[1]) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        bus.mem_memread = 1'b1;
        bus.mem_address = {2'b00, lat_addr[31:2]};
        state_next      = lat_write ? WR : RESP;
      end
      WR: begin
        bus.mem_memwrite   = 1'b1;
        bus.mem_address    = {2'b00, lat_addr[31:2]};
        bus.mem_write_data = store_word;
        state_next         = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, old-word capture and held response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr       <= 32'h0000_0000;
      lat_size       <= 2'b00;
      lat_signed     <= 1'b0;
      lat_write      <= 1'b0;
      lat_wdata      <= 32'h0000_0000;
      old_word       <= 32'h0000_0000;
      bus.resp_rdata <= 32'h0000_0000;
      bus.resp_err   <= 1'b0;
    end else if (accept) begin
      lat_addr       <= bus.req_addr;
      lat_size       <= bus.req_size;
      lat_signed     <= bus.req_signed;
      lat_write      <= bus.req_write;
      lat_wdata      <= bus.req_wdata;
      bus.resp_rdata <= 32'h0000_0000;
      bus.resp_err   <= misaligned;
    end else if (state == RD) begin
      // Memory data is only valid (and only sampled) while reading.
      old_word <= bus.mem_read_data;
      if (!lat_write) begin
        bus.resp_rdata <= extract_lane(bus.mem_read_data, lat_addr[1:0], lat_size, lat_signed);
      end
    end
  end

endmodule
